// File: rtl/txline_seq_pkg.sv
// Shared types and constants for the txline transmit sequencer.
// Holds the FSM state encoding and the preamble pattern used by the RTL and its checker.
// Preamble bit i is PRE_PATTERN[i % 32], giving 1,0,1,0... starting with 1.
package txline_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_GAP
  } seq_state_t;

  // Alternating preamble, bit 0 first; the pattern repeats every two bits so
  // any preamble length is covered by indexing modulo 32.
  localparam logic [31:0] PRE_PATTERN = 32'h5555_5555;

  function automatic logic pre_bit(input logic [4:0] i);
    return PRE_PATTERN[i];
  endfunction

endpackage

// File: rtl/txline_tx_sequencer_ui_timer.sv
// UI timer: counts clocks 0..UI_CYC-1 inside one unit interval.
// Latency: ui_end and the look-ahead strobes are combinational from the count register.
// Backpressure: none; clr holds the count at 0, otherwise it free-runs.
module ui_timer #(
  parameter int UI_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic ui_end,
  output logic ui_start_nxt,
  output logic ui_end_nxt
);

  localparam int CW = (UI_CYC > 1) ? $clog2(UI_CYC) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign ui_end       = (cnt == CW'(UI_CYC - 1));
  assign ui_start_nxt = (cnt_nxt == '0);
  assign ui_end_nxt   = (cnt_nxt == CW'(UI_CYC - 1));

  // Next count: cleared on request, wraps at the end of each UI
  always_comb begin
    cnt_nxt = cnt + 1'b1;
    if (clr || ui_end) begin
      cnt_nxt = '0;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/txline_tx_sequencer.sv
// txline sequencer: serializes words MSB-first at UI_CYC clocks/bit with preamble and idle gap.
// Latency: first preamble (or data) UI begins the clock after the accepting edge.
// Backpressure: s_ready only in IDLE, in the last clock of a non-last word, or while underrun.
module txline_tx_sequencer
  import txline_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int UI_CYC   = 4,
  parameter int PRE_LEN  = 4,
  parameter int IDLE_MIN = 2,
  parameter int RS_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RS_W-1:0]  cfg_rs_code,
  input  logic             cfg_inv,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             din,
  output logic             drv_en,
  output logic [RS_W-1:0]  rs_sel,
  output logic             bit_strobe,
  output logic             busy
);

  // idx counts preamble bits, data bits or gap UIs depending on state
  localparam int IDX_MAX = (WIDTH > PRE_LEN) ?
                           ((WIDTH > IDLE_MIN) ? WIDTH : IDLE_MIN) :
                           ((PRE_LEN > IDLE_MIN) ? PRE_LEN : IDLE_MIN);
  localparam int IDX_W = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_PLAST = IDX_W'(PRE_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_GLAST = IDX_W'(IDLE_MIN - 1);
  // A one-bit word's first UI is also its last, so a freshly loaded word may need s_ready at once
  localparam logic ONE_BIT = (WIDTH == 1);

  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             under;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_sh;
  logic             last_q;
  logic             inv_q;
  logic             accept;
  logic             ui_end;
  logic             ui_start_nxt;
  logic             ui_end_nxt;

  assign accept   = s_valid && s_ready;
  assign shreg_sh = shreg << 1;

  // UI timing is frozen at 0 while idle or starved so the next UI starts cleanly
  ui_timer #(
    .UI_CYC(UI_CYC)
  ) u_ui_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         ((state == ST_IDLE) || under),
    .ui_end      (ui_end),
    .ui_start_nxt(ui_start_nxt),
    .ui_end_nxt  (ui_end_nxt)
  );

  // Burst FSM with registered driver outputs and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      under      <= 1'b0;
      shreg      <= '0;
      last_q     <= 1'b0;
      inv_q      <= 1'b0;
      din        <= 1'b0;
      drv_en     <= 1'b0;
      rs_sel     <= '0;
      s_ready    <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg      <= s_data;
            last_q     <= s_last;
            inv_q      <= cfg_inv;
            rs_sel     <= cfg_rs_code;
            idx        <= '0;
            drv_en     <= 1'b1;
            busy       <= 1'b1;
            bit_strobe <= ui_start_nxt;
            if (PRE_LEN > 0) begin
              state   <= ST_PRE;
              din     <= pre_bit(5'd0);
              s_ready <= 1'b0;
            end else begin
              state   <= ST_DATA;
              din     <= s_data[WIDTH-1] ^ cfg_inv;
              s_ready <= ONE_BIT && ui_end_nxt && !s_last;
            end
          end else begin
            s_ready    <= 1'b1;
            din        <= 1'b0;
            drv_en     <= 1'b0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
          end
        end

        ST_PRE: begin
          s_ready    <= 1'b0;
          bit_strobe <= ui_start_nxt;
          if (ui_end) begin
            if (idx == IDX_PLAST) begin
              state   <= ST_DATA;
              idx     <= '0;
              din     <= shreg[WIDTH-1] ^ inv_q;
              s_ready <= ONE_BIT && ui_end_nxt && !last_q;
            end else begin
              idx <= idx + 1'b1;
              din <= pre_bit(5'(idx) + 5'd1);
            end
          end
        end

        ST_DATA: begin
          if (accept) begin
            // next word: either back-to-back or ending an underrun
            under      <= 1'b0;
            shreg      <= s_data;
            last_q     <= s_last;
            idx        <= '0;
            din        <= s_data[WIDTH-1] ^ inv_q;
            bit_strobe <= ui_start_nxt;
            s_ready    <= ONE_BIT && ui_end_nxt && !s_last;
          end else if (under) begin
            din        <= 1'b0;
            bit_strobe <= 1'b0;
            s_ready    <= 1'b1;
          end else if (ui_end && (idx == IDX_DLAST)) begin
            bit_strobe <= 1'b0;
            din        <= 1'b0;
            if (last_q) begin
              state   <= ST_GAP;
              idx     <= '0;
              drv_en  <= 1'b0;
              s_ready <= 1'b0;
            end else begin
              // starved: keep the line driven low until a word shows up
              under   <= 1'b1;
              s_ready <= 1'b1;
            end
          end else if (ui_end) begin
            shreg      <= shreg_sh;
            idx        <= idx + 1'b1;
            din        <= shreg_sh[WIDTH-1] ^ inv_q;
            bit_strobe <= ui_start_nxt;
            s_ready    <= ((idx + 1'b1) == IDX_DLAST) && ui_end_nxt && !last_q;
          end else begin
            bit_strobe <= ui_start_nxt;
            s_ready    <= (idx == IDX_DLAST) && ui_end_nxt && !last_q;
          end
        end

        ST_GAP: begin
          din        <= 1'b0;
          drv_en     <= 1'b0;
          bit_strobe <= 1'b0;
          if (ui_end) begin
            if (idx == IDX_GLAST) begin
              state   <= ST_IDLE;
              idx     <= '0;
              busy    <= 1'b0;
              s_ready <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_txline_tx_sequencer.sv
// Bench for txline_tx_sequencer: per-cycle model comparison plus literal burst checks.
// Instance a uses defaults (UI_CYC 4, PRE_LEN 4); instance b uses UI_CYC 1, PRE_LEN 0.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_txline_tx_sequencer;
  import txline_seq_pkg::*;

  localparam int A_UI = 4, A_PRE = 4, A_IDLE = 2;
  localparam int B_UI = 1, B_PRE = 0, B_IDLE = 2;
  localparam int M_COLD = 0, M_IDLE = 1, M_DRIVE = 2, M_GAP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, s_valid_a = 1'b0, s_last_a = 1'b0, cfg_inv_a = 1'b0;
  logic [7:0] s_data_a = 8'h00;
  logic [2:0] cfg_rs_a = 3'd0;
  logic       s_ready_a, din_a, drv_en_a, bit_strobe_a, busy_a;
  logic [2:0] rs_sel_a;

  logic       rst_b = 1'b1, s_valid_b = 1'b0, s_last_b = 1'b0, cfg_inv_b = 1'b0;
  logic [7:0] s_data_b = 8'h00;
  logic [2:0] cfg_rs_b = 3'd0;
  logic       s_ready_b, din_b, drv_en_b, bit_strobe_b, busy_b;
  logic [2:0] rs_sel_b;

  txline_tx_sequencer #(.WIDTH(8), .UI_CYC(A_UI), .PRE_LEN(A_PRE), .IDLE_MIN(A_IDLE), .RS_W(3)) dut_a (
    .clk(clk), .rst(rst_a), .cfg_rs_code(cfg_rs_a), .cfg_inv(cfg_inv_a),
    .s_valid(s_valid_a), .s_data(s_data_a), .s_last(s_last_a), .s_ready(s_ready_a),
    .din(din_a), .drv_en(drv_en_a), .rs_sel(rs_sel_a), .bit_strobe(bit_strobe_a), .busy(busy_a));

  txline_tx_sequencer #(.WIDTH(8), .UI_CYC(B_UI), .PRE_LEN(B_PRE), .IDLE_MIN(B_IDLE), .RS_W(3)) dut_b (
    .clk(clk), .rst(rst_b), .cfg_rs_code(cfg_rs_b), .cfg_inv(cfg_inv_b),
    .s_valid(s_valid_b), .s_data(s_data_b), .s_last(s_last_b), .s_ready(s_ready_b),
    .din(din_b), .drv_en(drv_en_b), .rs_sel(rs_sel_b), .bit_strobe(bit_strobe_b), .busy(busy_b));

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;
  bit started = 1'b0;

  // model state: expected line waveform as a queue of {din, strobe} per clock
  int         mode [2];
  int         qh [2];
  int         qt [2];
  int         gap_left [2];
  logic       m_last [2];
  logic       m_inv [2];
  logic [2:0] rs_exp [2];
  logic [1:0] qmem [2][256];

  // observed activity counters and captured bit stream per instance
  int          n_stb [2];
  int          n_drv [2];
  int          n_rdy [2];
  int          n_gap [2];
  logic [31:0] cap [2];
  int          snap_stb [2];
  int          snap_drv [2];
  int          snap_rdy [2];
  int          snap_gap [2];

  function automatic int uic(input int k);  return (k == 0) ? A_UI : B_UI;     endfunction
  function automatic int prl(input int k);  return (k == 0) ? A_PRE : B_PRE;   endfunction
  function automatic int idm(input int k);  return (k == 0) ? A_IDLE : B_IDLE; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input int k);
    case (mode[k])
      M_IDLE:  return 1'b1;
      M_DRIVE: return !m_last[k] && ((qt[k] - qh[k]) <= 1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_ui(input int k, input logic b);
    for (int c = 0; c < uic(k); c++) begin
      qmem[k][qt[k] % 256] = {b, (c == 0)};
      qt[k]++;
    end
  endtask

  task automatic push_word(input int k, input logic [7:0] d);
    for (int b = 0; b < 8; b++) push_ui(k, d[7-b] ^ m_inv[k]);
  endtask

  task automatic model_step(input int k, input logic r, input logic v, input logic l,
                            input logic inv, input logic [7:0] d, input logic [2:0] rs);
    logic acc;
    if (r) begin
      mode[k] = M_COLD; qh[k] = 0; qt[k] = 0; gap_left[k] = 0;
      m_last[k] = 1'b0; rs_exp[k] = 3'd0;
    end else begin
      acc = v && model_ready(k);
      case (mode[k])
        M_COLD: mode[k] = M_IDLE;
        M_IDLE: if (acc) begin
          rs_exp[k] = rs; m_inv[k] = inv;
          for (int p = 0; p < prl(k); p++) push_ui(k, PRE_PATTERN[p % 32]);
          push_word(k, d); m_last[k] = l; mode[k] = M_DRIVE;
        end
        M_DRIVE: begin
          if (qt[k] != qh[k]) qh[k]++;
          if (acc) begin push_word(k, d); m_last[k] = l; end
          if (qt[k] == qh[k] && m_last[k]) begin
            mode[k] = M_GAP; gap_left[k] = idm(k) * uic(k);
          end
        end
        default: begin
          gap_left[k]--;
          if (gap_left[k] == 0) mode[k] = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic check_inst(input int k, input logic o_din, input logic o_drv, input logic o_stb,
                            input logic o_rdy, input logic o_busy, input logic [2:0] o_rs);
    logic e_din, e_drv, e_stb, e_busy;
    e_din = 1'b0; e_drv = 1'b0; e_stb = 1'b0; e_busy = 1'b0;
    if (mode[k] == M_DRIVE) begin
      e_drv = 1'b1; e_busy = 1'b1;
      if (qt[k] != qh[k]) begin
        e_din = qmem[k][qh[k] % 256][1];
        e_stb = qmem[k][qh[k] % 256][0];
      end
    end else if (mode[k] == M_GAP) begin
      e_busy = 1'b1;
    end
    chk($sformatf("din%0d", k), o_din, e_din);
    chk($sformatf("drv_en%0d", k), o_drv, e_drv);
    chk($sformatf("bit_strobe%0d", k), o_stb, e_stb);
    chk($sformatf("s_ready%0d", k), o_rdy, model_ready(k));
    chk($sformatf("busy%0d", k), o_busy, e_busy);
    chk($sformatf("rs_sel%0d", k), o_rs, rs_exp[k]);
    if (o_stb) begin n_stb[k]++; cap[k] = {cap[k][30:0], o_din}; end
    if (o_drv) n_drv[k]++;
    if (o_drv && o_rdy) n_rdy[k]++;
    if (o_busy && !o_drv) n_gap[k]++;
  endtask

  task automatic monitor_loop();
    while (!done) begin
      @(posedge clk);
      model_step(0, rst_a, s_valid_a, s_last_a, cfg_inv_a, s_data_a, cfg_rs_a);
      model_step(1, rst_b, s_valid_b, s_last_b, cfg_inv_b, s_data_b, cfg_rs_b);
      if (rst_a && rst_b) started = 1'b1;
      #1;
      if (started) begin
        check_inst(0, din_a, drv_en_a, bit_strobe_a, s_ready_a, busy_a, rs_sel_a);
        check_inst(1, din_b, drv_en_b, bit_strobe_b, s_ready_b, busy_b, rs_sel_b);
      end
    end
  endtask

  function automatic logic get_rdy(input int k);  return (k == 0) ? s_ready_a : s_ready_b; endfunction
  function automatic logic get_busy(input int k); return (k == 0) ? busy_a : busy_b;       endfunction

  task automatic set_word(input int k, input logic v, input logic [7:0] d, input logic l);
    if (k == 0) begin s_valid_a = v; s_data_a = d; s_last_a = l; end
    else        begin s_valid_b = v; s_data_b = d; s_last_b = l; end
  endtask

  // present a word, wait for the handshake, return on the falling edge after acceptance
  task automatic send(input int k, input logic [7:0] d, input logic l, input bit drop);
    int n;
    n = 0;
    set_word(k, 1'b1, d, l);
    while (!get_rdy(k) && n < 300) begin @(negedge clk); n++; end
    chk("handshake_seen", get_rdy(k), 1);
    @(negedge clk);
    if (drop) set_word(k, 1'b0, d, l);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!(!get_busy(k) && get_rdy(k)) && n < 1000) begin @(negedge clk); n++; end
    chk("idle_reached", n < 1000, 1);
  endtask

  task automatic snap(input int k);
    snap_stb[k] = n_stb[k]; snap_drv[k] = n_drv[k];
    snap_rdy[k] = n_rdy[k]; snap_gap[k] = n_gap[k];
  endtask

  task automatic expect_burst(input string name, input int k, input int stb, input int drv,
                              input int rdy, input int gap);
    chk({name, "_strobes"},  n_stb[k] - snap_stb[k], stb);
    chk({name, "_drv_clks"}, n_drv[k] - snap_drv[k], drv);
    chk({name, "_rdy_drv"},  n_rdy[k] - snap_rdy[k], rdy);
    chk({name, "_gap_clks"}, n_gap[k] - snap_gap[k], gap);
  endtask

  task automatic run_tests();
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // reset mid-DATA: burst abandoned, outputs back to reset values
    cfg_rs_a = 3'd6;
    send(0, 8'hF0, 1'b1, 1'b1);
    repeat (24) @(negedge clk);
    chk("mid_burst_drv_en", drv_en_a, 1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("rst_din", din_a, 0);
    chk("rst_drv_en", drv_en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_s_ready", s_ready_a, 0);
    chk("rst_rs_sel", rs_sel_a, 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("rst_release_s_ready", s_ready_a, 1);

    // single word A5: preamble 1010 then 10100101
    cfg_rs_a = 3'd0;
    snap(0);
    send(0, 8'hA5, 1'b1, 1'b1);
    wait_idle(0);
    chk("single_bits", cap[0][11:0], 12'hAA5);
    expect_burst("single", 0, 12, 48, 0, 8);

    // two words back to back
    snap(0);
    send(0, 8'hFF, 1'b0, 1'b0);
    send(0, 8'h00, 1'b1, 1'b1);
    wait_idle(0);
    chk("b2b_bits", cap[0][19:0], 20'hAFF00);
    expect_burst("b2b", 0, 20, 80, 1, 8);

    // underrun: second word presented 10 clocks after the first one runs dry
    snap(0);
    send(0, 8'hC3, 1'b0, 1'b1);
    repeat (57) @(negedge clk);
    send(0, 8'h3C, 1'b1, 1'b1);
    wait_idle(0);
    chk("underrun_bits", cap[0][19:0], 20'hAC33C);
    expect_burst("underrun", 0, 20, 90, 11, 8);

    // inverted data, config changed mid-burst is ignored
    cfg_inv_a = 1'b1; cfg_rs_a = 3'd5;
    snap(0);
    send(0, 8'h96, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    cfg_inv_a = 1'b0; cfg_rs_a = 3'd2;
    wait_idle(0);
    chk("inv_bits", cap[0][11:0], 12'hA69);
    chk("inv_rs_sel_held", rs_sel_a, 5);
    expect_burst("inv", 0, 12, 48, 0, 8);

    // no preamble, one clock per bit
    cfg_rs_b = 3'd3;
    snap(1);
    send(1, 8'hA5, 1'b0, 1'b0);
    send(1, 8'h5A, 1'b1, 1'b1);
    wait_idle(1);
    chk("fast_bits", cap[1][15:0], 16'hA55A);
    chk("fast_rs_sel", rs_sel_b, 3);
    expect_burst("fast", 1, 16, 16, 1, 2);

    repeat (4) @(negedge clk);
    done = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_COLD; qh[k] = 0; qt[k] = 0; gap_left[k] = 0;
      m_last[k] = 1'b0; m_inv[k] = 1'b0; rs_exp[k] = 3'd0;
      n_stb[k] = 0; n_drv[k] = 0; n_rdy[k] = 0; n_gap[k] = 0; cap[k] = '0;
      snap_stb[k] = 0; snap_drv[k] = 0; snap_rdy[k] = 0; snap_gap[k] = 0;
    end
    fork
      monitor_loop();
      run_tests();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
